// File: rtl/updown_counter_cascade.sv
// Synchronous up/down counter of DIGITS cascaded 4-bit stages (binary or decade per stage),
// with TTL-style load, dual enables, combinational ripple carry and a registered wrap pulse.
module updown_counter_cascade #(
  parameter int DIGITS = 2,
  parameter bit DECADE = 1'b0
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [4*DIGITS-1:0] d_in,
  input  logic                load,
  input  logic                n_en_p,
  input  logic                n_en_t,
  input  logic                u_d,
  output logic [4*DIGITS-1:0] d_out,
  output logic                n_rco,
  output logic                tc_pulse
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]      cnt_q, cnt_d;
  logic              tc_q, tc_d;
  logic [DIGITS-1:0] term;
  logic              all_term;
  logic              step_en;

  function automatic logic nib_term(input logic [3:0] nib, input logic up);
    if (up) return DECADE ? (nib == 4'd9) : (nib == 4'd15);
    return nib == 4'd0;
  endfunction

  // Out-of-range decade values (10..15) fall through to plain mod-16 stepping.
  function automatic logic [3:0] nib_step(input logic [3:0] nib, input logic up);
    if (up) return (DECADE && nib == 4'd9) ? 4'd0 : nib + 4'd1;
    return (DECADE && nib == 4'd0) ? 4'd9 : nib - 4'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      term[i] = nib_term(cnt_q[4*i +: 4], u_d);
    end
    all_term = &term;
  end

  assign n_rco = ~(~n_en_t & all_term);

  always_comb begin
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    step_en = 1'b1;
    if (!load) begin
      cnt_d = d_in;
    end else if (!n_en_p && !n_en_t) begin
      // Stage i advances only while every lower stage sits at its terminal value.
      for (int i = 0; i < DIGITS; i++) begin
        if (step_en) cnt_d[4*i +: 4] = nib_step(cnt_q[4*i +: 4], u_d);
        step_en = step_en & term[i];
      end
      tc_d = all_term;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign d_out    = cnt_q;
  assign tc_pulse = tc_q;

endmodule

// File: tb/tb_updown_counter_cascade.sv
// Bench for updown_counter_cascade: binary 2-digit, decade 2-digit and a chained pair of
// 1-digit decade counters, all checked against integer-valued reference models.
module tb_updown_counter_cascade;

  logic clk;

  logic       b_rst, b_load, b_p, b_t, b_ud;
  logic [7:0] b_d, b_out;
  logic       b_rco, b_tc;

  logic       d_rst, d_load, d_p, d_t, d_ud;
  logic [7:0] d_d, d_out;
  logic       d_rco, d_tc;

  logic [3:0] l_out, h_out;
  logic       l_rco, l_tc, h_rco, h_tc;

  int total = 0, passed = 0, fails = 0;

  int bv = 0;  logic btc = 1'b0;
  int dv = 0;  logic dtc = 1'b0, ltc = 1'b0, dok = 1'b1;

  updown_counter_cascade #(.DIGITS(2), .DECADE(1'b0)) u_bin (
    .clk(clk), .n_reset(b_rst), .d_in(b_d), .load(b_load), .n_en_p(b_p), .n_en_t(b_t),
    .u_d(b_ud), .d_out(b_out), .n_rco(b_rco), .tc_pulse(b_tc));

  updown_counter_cascade #(.DIGITS(2), .DECADE(1'b1)) u_dec (
    .clk(clk), .n_reset(d_rst), .d_in(d_d), .load(d_load), .n_en_p(d_p), .n_en_t(d_t),
    .u_d(d_ud), .d_out(d_out), .n_rco(d_rco), .tc_pulse(d_tc));

  updown_counter_cascade #(.DIGITS(1), .DECADE(1'b1)) u_lo (
    .clk(clk), .n_reset(d_rst), .d_in(d_d[3:0]), .load(d_load), .n_en_p(d_p), .n_en_t(d_t),
    .u_d(d_ud), .d_out(l_out), .n_rco(l_rco), .tc_pulse(l_tc));

  updown_counter_cascade #(.DIGITS(1), .DECADE(1'b1)) u_hi (
    .clk(clk), .n_reset(d_rst), .d_in(d_d[7:4]), .load(d_load), .n_en_p(d_p), .n_en_t(l_rco),
    .u_d(d_ud), .d_out(h_out), .n_rco(h_rco), .tc_pulse(h_tc));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Advance both reference models by one clock edge using the inputs currently applied.
  task automatic model_edge();
    if (!b_rst) begin
      bv = 0; btc = 1'b0;
    end else if (!b_load) begin
      bv = int'(b_d); btc = 1'b0;
    end else if (!b_p && !b_t) begin
      btc = b_ud ? (bv == 255) : (bv == 0);
      bv  = b_ud ? (bv + 1) % 256 : (bv + 255) % 256;
    end else begin
      btc = 1'b0;
    end

    if (!d_rst) begin
      dv = 0; dtc = 1'b0; ltc = 1'b0; dok = 1'b1;
    end else if (!d_load) begin
      dok = (d_d[7:4] < 4'd10) && (d_d[3:0] < 4'd10);
      dv  = 10 * int'(d_d[7:4]) + int'(d_d[3:0]);
      dtc = 1'b0; ltc = 1'b0;
    end else if (!d_p && !d_t) begin
      ltc = d_ud ? (dv % 10 == 9) : (dv % 10 == 0);
      dtc = d_ud ? (dv == 99) : (dv == 0);
      if (dok) dv = d_ud ? (dv + 1) % 100 : (dv + 99) % 100;
    end else begin
      dtc = 1'b0; ltc = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("bin_out", b_out, bv);
    chk("bin_tc",  b_tc,  btc);
    chk("bin_rco", b_rco, !(!b_t && (b_ud ? bv == 255 : bv == 0)));
    if (dok) begin
      chk("dec_out",  d_out, bcd(dv));
      chk("dec_tc",   d_tc,  dtc);
      chk("dec_rco",  d_rco, !(!d_t && (d_ud ? dv == 99 : dv == 0)));
      chk("casc_out", {h_out, l_out}, bcd(dv));
      chk("casc_tc",  h_tc,  dtc);
      chk("casc_ltc", l_tc,  ltc);
      chk("casc_rco", h_rco, !(!d_t && (d_ud ? dv == 99 : dv == 0)));
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    clk = 1'b0;
    b_rst = 1'b0; b_load = 1'b1; b_p = 1'b1; b_t = 1'b1; b_ud = 1'b1; b_d = 8'h00;
    d_rst = 1'b0; d_load = 1'b1; d_p = 1'b1; d_t = 1'b1; d_ud = 1'b1; d_d = 8'h00;
    #12;
    check_all();
    b_rst = 1'b1; d_rst = 1'b1;

    // Full binary sweep through the wrap.
    b_p = 1'b0; b_t = 1'b0;
    repeat (256) tick();
    chk("bin_sweep_end", b_out, 8'h00);
    chk("bin_sweep_tc", b_tc, 1'b1);

    // Decade wrap up, then down across zero.
    d_load = 1'b0; d_d = 8'h98;
    tick();
    d_load = 1'b1; d_p = 1'b0; d_t = 1'b0;
    repeat (3) tick();
    chk("dec_at_01", d_out, 8'h01);
    d_ud = 1'b0;
    tick();
    chk("dec_down_rco", d_rco, 1'b0);
    tick();
    chk("dec_down_wrap", d_out, 8'h99);
    chk("dec_down_tc", d_tc, 1'b1);

    // Enable gating: P alone holds, T gates the carry.
    b_load = 1'b0; b_d = 8'hFF;
    tick();
    b_load = 1'b1; b_p = 1'b1; b_t = 1'b0; b_ud = 1'b1;
    repeat (2) tick();
    chk("gate_hold", b_out, 8'hFF);
    chk("gate_rco_low", b_rco, 1'b0);
    b_t = 1'b1;
    #1;
    check_all();
    chk("gate_rco_high", b_rco, 1'b1);
    tick();

    // Load beats enabled counting.
    b_p = 1'b0; b_t = 1'b0; b_load = 1'b0; b_d = 8'h3C;
    tick();
    chk("load_prio", b_out, 8'h3C);
    chk("load_prio_tc", b_tc, 1'b0);

    // Asynchronous reset between edges.
    b_d = 8'h57;
    tick();
    b_load = 1'b1; b_p = 1'b1; b_t = 1'b1;
    #2;
    b_rst = 1'b0;
    #1;
    bv = 0; btc = 1'b0;
    chk("async_rst_out", b_out, 8'h00);
    chk("async_rst_tc", b_tc, 1'b0);
    #2;
    b_rst = 1'b1; b_p = 1'b0; b_t = 1'b0;
    tick();
    chk("after_rst", b_out, 8'h01);

    // Out-of-range decade digits.
    d_load = 1'b0; d_d = 8'h0F; d_ud = 1'b1;
    tick();
    chk("oor_load", d_out, 8'h0F);
    chk("oor_load_casc", {h_out, l_out}, 8'h0F);
    d_load = 1'b1;
    tick();
    chk("oor_up", d_out, 8'h00);
    chk("oor_up_casc", {h_out, l_out}, 8'h00);
    chk("oor_up_tc", d_tc, 1'b0);
    d_load = 1'b0; d_d = 8'hA0; d_ud = 1'b0;
    tick();
    d_load = 1'b1;
    #1;
    chk("oor_rco", d_rco, 1'b1);
    tick();
    chk("oor_down", d_out, 8'h99);
    chk("oor_down_casc", {h_out, l_out}, 8'h99);
    chk("oor_down_tc", d_tc, 1'b0);
    dv = 99; dok = 1'b1;

    // Decade sweeps in both directions, then randomized traffic on both counters.
    d_ud = 1'b1;
    repeat (120) tick();
    d_ud = 1'b0;
    repeat (120) tick();
    repeat (400) begin
      b_load = ($urandom_range(15) != 0);
      b_d    = 8'($urandom);
      b_p    = ($urandom_range(7) == 0);
      b_t    = ($urandom_range(7) == 0);
      b_ud   = 1'($urandom_range(1));
      d_load = ($urandom_range(15) != 0);
      d_d    = {4'($urandom_range(9)), 4'($urandom_range(9))};
      d_p    = ($urandom_range(7) == 0);
      d_t    = ($urandom_range(7) == 0);
      d_ud   = ($urandom_range(3) != 0) ? d_ud : ~d_ud;
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
